// File: rtl/bus_slave_mem_pkg.sv
// Shared types and bus widths for the serial bus slave with local byte memory.
package bus_pkg;

    localparam int BUS_ADDR_BITS = 16;
    localparam int BUS_DATA_BITS = 8;
    localparam int SLAVE_ID_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        IGNORE,
        WDATA,
        ACK_WR,
        RWAIT,
        RDATA
    } slave_state_t;

endpackage

// File: rtl/bus_slave_mem_if.sv
// Shared 1-bit serial bus between the bus master and a memory slave.
interface bus_slave_mem_if;

    logic S_UTIL;
    logic S_RW;
    logic S_BUS_IN;
    logic S_BUS_OUT;
    logic S_READY;
    logic S_ACK;
    logic S_BUSY;

    modport slave (
        input  S_UTIL, S_RW, S_BUS_IN,
        output S_BUS_OUT, S_READY, S_ACK, S_BUSY
    );

    modport master (
        output S_UTIL, S_RW, S_BUS_IN,
        input  S_BUS_OUT, S_READY, S_ACK, S_BUSY
    );

endinterface

// File: rtl/bus_slave_mem_slave_mem.sv
// Byte RAM: one synchronous write port, asynchronous read on the same address.
module slave_mem
    import bus_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [BUS_DATA_BITS-1:0] wdata_i,
    output logic [BUS_DATA_BITS-1:0] rdata_o
);

    // Contents are deliberately not reset so the array maps onto plain RAM.
    logic [BUS_DATA_BITS-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/counter.sv
// Shared up-counter with synchronous clear (clear wins over enable).
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_slave_mem.sv
// Serial bus slave: LSB-first address/ID decode, ACK handshake, byte write/read.
// Define SLAVE_WAIT_EN to insert two RWAIT cycles between the read ACK and data.
module bus_slave_mem
    import bus_pkg::*;
#(
    parameter logic [SLAVE_ID_W-1:0] SLAVE_ID = 4'h2,
    parameter int                    ADDR_W   = 12
) (
    input logic           clk,
    input logic           rst,
    bus_slave_mem_if.slave bus
);

    slave_state_t             state_q, state_d;
    logic [BUS_ADDR_BITS-1:0] addr_q, addr_d;
    logic [BUS_DATA_BITS-1:0] wbuf_q, wbuf_d;
    logic                     ack_q, ack_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic                     busOut_q, busOut_d;

    logic [3:0]               cnt;
    logic                     cntClr;
    logic                     cntEn;
    logic [2:0]               cntNext;
    logic [BUS_DATA_BITS-1:0] rdata;
    logic                     memWe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wbuf_q   <= '0;
            ack_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            busOut_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wbuf_q   <= wbuf_d;
            ack_q    <= ack_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            busOut_q <= busOut_d;
        end
    end

    // Outputs are registered, so they are derived from the next state/count.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        ack_d   = 1'b0;
        cntClr  = 1'b0;
        cntEn   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.S_UTIL) begin
                    addr_d[0] = bus.S_BUS_IN;
                    cntEn     = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (!bus.S_UTIL) begin
                    cntClr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d[cnt] = bus.S_BUS_IN;
                    if (cnt == 4'(BUS_ADDR_BITS - 1)) begin
                        cntClr  = 1'b1;
                        state_d = ACK_ADDR;
                        ack_d   = (addr_d[BUS_ADDR_BITS-1 -: SLAVE_ID_W] == SLAVE_ID);
                    end else begin
                        cntEn = 1'b1;
                    end
                end
            end
            ACK_ADDR: begin
                if (addr_q[BUS_ADDR_BITS-1 -: SLAVE_ID_W] != SLAVE_ID) begin
                    state_d = IGNORE;
                end else if (bus.S_RW) begin
                    state_d = WDATA;
                end else begin
`ifdef SLAVE_WAIT_EN
                    state_d = RWAIT;
`else
                    state_d = RDATA;
`endif
                end
            end
            IGNORE: begin
                if (!bus.S_UTIL) begin
                    state_d = IDLE;
                end
            end
            WDATA: begin
                if (!bus.S_UTIL) begin
                    cntClr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wbuf_d[cnt[2:0]] = bus.S_BUS_IN;
                    if (cnt == 4'(BUS_DATA_BITS - 1)) begin
                        cntClr  = 1'b1;
                        state_d = ACK_WR;
                        ack_d   = 1'b1;
                    end else begin
                        cntEn = 1'b1;
                    end
                end
            end
            ACK_WR: begin
                state_d = IDLE;
            end
            RWAIT: begin
                if (cnt == 4'd1) begin
                    cntClr  = 1'b1;
                    state_d = RDATA;
                end else begin
                    cntEn = 1'b1;
                end
            end
            RDATA: begin
                if (cnt == 4'(BUS_DATA_BITS - 1)) begin
                    cntClr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cntEn = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cntNext  = cntClr ? 3'd0 : (cntEn ? cnt[2:0] + 3'd1 : cnt[2:0]);
        ready_d  = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
        busOut_d = (state_d == RDATA) ? rdata[cntNext] : 1'b0;
    end

    assign memWe = (state_q == ACK_WR);

    counter #(
        .WIDTH(4)
    ) uBitCnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cntClr),
        .en_i  (cntEn),
        .cnt_o (cnt)
    );

    slave_mem #(
        .ADDR_W(ADDR_W)
    ) uMem (
        .clk     (clk),
        .we_i    (memWe),
        .addr_i  (addr_q[ADDR_W-1:0]),
        .wdata_i (wbuf_q),
        .rdata_o (rdata)
    );

    assign bus.S_BUS_OUT = busOut_q;
    assign bus.S_READY   = ready_q;
    assign bus.S_ACK     = ack_q;
    assign bus.S_BUSY    = busy_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Scoreboard bench for bus_slave_mem: stimulus queues expected ACKs/read bytes,
// a monitor pops and compares them as the slave produces them.
module tb_bus_slave_mem;

`ifdef SLAVE_WAIT_EN
    localparam int RD_DELAY = 3;
`else
    localparam int RD_DELAY = 1;
`endif

    typedef struct {
        int         cycle;
        bit         isRead;
        logic [7:0] data;
        string      name;
    } expEvt_t;

    logic    clk;
    logic    rst;
    int      cyc = 0;
    int      nTests = 0;
    int      nFail = 0;
    bit      rdActive = 0;
    expEvt_t expQ[$];

    bus_slave_mem_if busIf ();

    bus_slave_mem #(
        .SLAVE_ID(4'h2),
        .ADDR_W  (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nTests++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drives one bus cycle on the falling edge; the slave samples it on the next rising edge.
    task automatic applyStimulus(input logic util, input logic rw, input logic bitIn);
        @(negedge clk);
        busIf.S_UTIL   = util;
        busIf.S_RW     = rw;
        busIf.S_BUS_IN = bitIn;
    endtask

    task automatic sendAddr(input logic [15:0] addr, input logic rw, input bit expAck,
                            input bit isRead, input logic [7:0] rdExp, input string name);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, rw, addr[i]);
        if (expAck) expQ.push_back('{cycle: cyc + 1, isRead: isRead, data: rdExp, name: name});
    endtask

    task automatic doWrite(input logic [15:0] addr, input logic [7:0] data, input string name);
        sendAddr(addr, 1'b1, 1'b1, 1'b0, 8'h00, {name, " addr"});
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, data[i]);
        expQ.push_back('{cycle: cyc + 1, isRead: 1'b0, data: 8'h00, name: {name, " data"}});
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic doRead(input logic [15:0] addr, input logic [7:0] expData, input string name);
        sendAddr(addr, 1'b0, 1'b1, 1'b1, expData, name);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (RD_DELAY + 9) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: matches every ACK against the queue and assembles read bytes.
    initial begin
        int         rdStart;
        int         k;
        logic [7:0] rdGot;
        logic [7:0] rdExp;
        string      rdName;
        bit         prevAck;
        expEvt_t    e;
        rdStart = 0;
        rdGot   = '0;
        rdExp   = '0;
        prevAck = 1'b0;
        forever begin
            @(negedge clk);
            if (rdActive) begin
                if (cyc >= rdStart && cyc < rdStart + 8) begin
                    k = cyc - rdStart;
                    rdGot[k[2:0]] = busIf.S_BUS_OUT;
                end else if (cyc == rdStart + 8) begin
                    checkOutput({rdName, " read byte"}, int'(rdGot), int'(rdExp));
                    checkOutput({rdName, " ready after read"}, int'(busIf.S_READY), 1);
                    checkOutput({rdName, " bus_out idle"}, int'(busIf.S_BUS_OUT), 0);
                    rdActive = 1'b0;
                end
            end
            if (busIf.S_ACK === 1'b1) begin
                checkOutput("ack single cycle", int'(prevAck), 0);
                if (expQ.size() == 0) begin
                    nTests++;
                    nFail++;
                    $display("[TB] FAIL unexpected ack: got ack at cycle %0d, required none", cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, " ack cycle"}, cyc, e.cycle);
                    if (e.isRead) begin
                        rdActive = 1'b1;
                        rdStart  = cyc + RD_DELAY;
                        rdExp    = e.data;
                        rdName   = e.name;
                        rdGot    = '0;
                    end
                end
            end
            prevAck = (busIf.S_ACK === 1'b1);
        end
    end

    initial begin
        logic [15:0] a2005;
        logic [7:0]  rstData;
        a2005          = 16'h2005;
        rstData        = 8'h3C;
        rst            = 1'b1;
        busIf.S_UTIL   = 1'b0;
        busIf.S_RW     = 1'b0;
        busIf.S_BUS_IN = 1'b0;

        @(negedge clk);
        checkOutput("reset S_BUS_OUT", int'(busIf.S_BUS_OUT), 0);
        checkOutput("reset S_ACK", int'(busIf.S_ACK), 0);
        checkOutput("reset S_READY", int'(busIf.S_READY), 1);
        checkOutput("reset S_BUSY", int'(busIf.S_BUSY), 0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        doWrite(16'h2005, 8'hA5, "wr 2005");
        doRead(16'h2005, 8'hA5, "rd 2005");
        doWrite(16'h2FFF, 8'h5A, "wr 2FFF");
        doRead(16'h2FFF, 8'h5A, "rd 2FFF");
        doRead(16'h2005, 8'hA5, "rd 2005 again");

        // ID mismatch: slave stays busy until UTIL drops, never ACKs.
        sendAddr(16'h3005, 1'b1, 1'b0, 1'b0, 8'h00, "id mismatch");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOutput("mismatch S_READY", int'(busIf.S_READY), 0);
            checkOutput("mismatch S_BUSY", int'(busIf.S_BUSY), 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("mismatch idle S_READY", int'(busIf.S_READY), 1);
        checkOutput("mismatch idle S_BUSY", int'(busIf.S_BUSY), 0);

        // Address abort after 9 bits.
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, a2005[i]);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("addr abort busy", int'(busIf.S_BUSY), 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("addr abort S_READY", int'(busIf.S_READY), 1);
        checkOutput("addr abort S_BUSY", int'(busIf.S_BUSY), 0);

        // Write abort after 4 data bits must leave memory untouched.
        sendAddr(16'h2005, 1'b1, 1'b1, 1'b0, 8'h00, "abort wr addr");
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wr abort S_READY", int'(busIf.S_READY), 1);
        doRead(16'h2005, 8'hA5, "rd after abort");

        // Reset during data bit 3 of a write.
        sendAddr(16'h2005, 1'b1, 1'b1, 1'b0, 8'h00, "rst wr addr");
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, rstData[i]);
        applyStimulus(1'b1, 1'b1, rstData[3]);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid rst S_BUS_OUT", int'(busIf.S_BUS_OUT), 0);
        checkOutput("mid rst S_ACK", int'(busIf.S_ACK), 0);
        checkOutput("mid rst S_READY", int'(busIf.S_READY), 1);
        checkOutput("mid rst S_BUSY", int'(busIf.S_BUSY), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        doRead(16'h2005, 8'hA5, "rd after rst");

        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        while (expQ.size() != 0) begin
            expQ.pop_front();
            nTests++;
            nFail++;
            $display("[TB] FAIL missing ack: got none, required ack by cycle %0d", cyc);
        end
        if (rdActive) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL read incomplete: got partial read, required 8 bits");
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
